// File: rtl/pulse_timing_pkg.sv
// rtl/pulse_timing_pkg.sv - shared constants and state type for the PPS timebase
// Purpose: default rates, divider constants, counter widths and the lock FSM state enum.
// Ports: none (package).
package pulse_timing_pkg;

  localparam int CLK_HZ_DEFAULT  = 10_000_000;
  localparam int PPS_TOL_DEFAULT = 1000;
  localparam int US_DIV          = CLK_HZ_DEFAULT / 1_000_000;
  localparam int MS_DIV          = 1000;

  localparam int SUB_W = 24;
  localparam int PER_W = 25;
  localparam int REJ_W = 8;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } pps_state_e;

endpackage

// File: rtl/pps_synchronizer.sv
// rtl/pps_synchronizer.sv - two-flop PPS synchronizer with registered rising-edge pulse
// Purpose: bring the asynchronous GPS PPS into the clock domain and emit a one-cycle
//          pulse two cycles after the edge is first sampled.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset, clears every stage
//   pps_async in  raw PPS from the receiver
//   pps_rise  out one-cycle pulse per PPS rising edge
module pps_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic pps_async,
  output logic pps_rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      sync_d   <= 1'b0;
      pps_rise <= 1'b0;
    end else begin
      meta     <= pps_async;
      sync     <= meta;
      sync_d   <= sync;
      pps_rise <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/pps_timebase_10mhz.sv
// rtl/pps_timebase_10mhz.sv - PPS-disciplined seconds/sub-second timebase with tick strobes
// Purpose: free-running seconds and sub-second counters that realign to accepted PPS
//          edges, PPS period measurement, lock tracking and 1 us / 1 ms / 1 s strobes.
// Ports:
//   CLK_10MHZ_Input         in  system clock
//   RST_Input               in  synchronous active-high reset
//   PPS_Input               in  asynchronous PPS
//   Seconds_Load_Valid      in  strobe loading the seconds counter
//   Seconds_Load_Value      in  value for the load
//   Seconds_Output          out seconds count
//   Subsecond_Output        out cycle within the second, 0..CLK_HZ-1
//   Tick_1US_Output         out microsecond strobe
//   Tick_1MS_Output         out millisecond strobe
//   Tick_1S_Output          out second-boundary strobe
//   PPS_Locked_Output       out high while LOCKED
//   Period_Measured_Output  out cycles between the last two accepted PPS edges
//   Period_Valid_Output     out strobe on each period update
//   PPS_Reject_Count_Output out saturating count of out-of-window PPS edges
module pps_timebase_10mhz #(
  parameter int CLK_HZ  = pulse_timing_pkg::CLK_HZ_DEFAULT,
  parameter int PPS_TOL = pulse_timing_pkg::PPS_TOL_DEFAULT,
  parameter int SEC_W   = 32,
  parameter int US_DIV  = CLK_HZ / 1_000_000
) (
  input  logic             CLK_10MHZ_Input,
  input  logic             RST_Input,
  input  logic             PPS_Input,
  input  logic             Seconds_Load_Valid,
  input  logic [SEC_W-1:0] Seconds_Load_Value,
  output logic [SEC_W-1:0] Seconds_Output,
  output logic [23:0]      Subsecond_Output,
  output logic             Tick_1US_Output,
  output logic             Tick_1MS_Output,
  output logic             Tick_1S_Output,
  output logic             PPS_Locked_Output,
  output logic [24:0]      Period_Measured_Output,
  output logic             Period_Valid_Output,
  output logic [7:0]       PPS_Reject_Count_Output
);

  import pulse_timing_pkg::*;

  localparam int US_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int MS_W = $clog2(MS_DIV);

  localparam logic [PER_W-1:0] PER_MAX  = '1;
  localparam logic [PER_W-1:0] WIN_LO   = PER_W'(CLK_HZ - PPS_TOL);
  localparam logic [PER_W-1:0] WIN_HI   = PER_W'(CLK_HZ + PPS_TOL);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_HZ - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(CLK_HZ / 2);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(US_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_DIV - 1);
  localparam logic [REJ_W-1:0] REJ_MAX  = '1;

  logic             clk;
  logic             rst;
  logic             pps_rise;

  pps_state_e       state;
  pps_state_e       state_next;
  logic             realign;
  logic             store;
  logic             reject;

  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] elapsed;
  logic             in_window;
  logic             timed_out;

  logic [SUB_W-1:0] sub_cnt;
  logic [SEC_W-1:0] sec_cnt;
  logic [US_W-1:0]  us_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             sub_wrap;
  logic             sec_inc;
  logic             us_fire;

  logic             tick_us;
  logic             tick_ms;
  logic             tick_s;
  logic             locked;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic [REJ_W-1:0] rej_cnt;

  assign clk = CLK_10MHZ_Input;
  assign rst = RST_Input;

  pps_synchronizer u_sync (
    .clk       (clk),
    .rst       (rst),
    .pps_async (PPS_Input),
    .pps_rise  (pps_rise)
  );

  // per_cnt holds the cycles completed since the last accepted edge; elapsed
  // includes the current cycle, so an edge exactly CLK_HZ cycles after the
  // previous one measures as CLK_HZ.
  assign elapsed   = (per_cnt == PER_MAX) ? per_cnt : per_cnt + PER_W'(1);
  assign in_window = (elapsed >= WIN_LO) && (elapsed <= WIN_HI);
  assign timed_out = (elapsed > WIN_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FREE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FREE: begin
        if (pps_rise) state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (pps_rise) begin
          if (in_window) state_next = LOCKED;
        end else if (timed_out) begin
          state_next = FREE;
        end
      end
      LOCKED: begin
        if (!pps_rise && timed_out) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  // Realign also restarts the period measurement; an edge rejected while
  // LOCKED leaves per_cnt running so the next good edge is still measured
  // from the last accepted one.
  always_comb begin
    realign = 1'b0;
    store   = 1'b0;
    reject  = 1'b0;
    case (state)
      FREE: begin
        realign = pps_rise;
      end
      ACQUIRE: begin
        realign = pps_rise;
        store   = pps_rise && in_window;
      end
      LOCKED: begin
        realign = pps_rise && in_window;
        store   = pps_rise && in_window;
        reject  = pps_rise && !in_window;
      end
      default: begin
        realign = 1'b0;
      end
    endcase
  end

  assign sub_wrap = (sub_cnt == SUB_LAST);
  assign us_fire  = (us_cnt == US_LAST);
  // An early edge has not yet seen the natural wrap, so it supplies the
  // increment itself; a late edge already had its second counted.
  assign sec_inc  = realign ? (sub_cnt >= SUB_HALF) : sub_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt      <= '0;
      sub_cnt      <= '0;
      sec_cnt      <= '0;
      us_cnt       <= '0;
      ms_cnt       <= '0;
      tick_us      <= 1'b0;
      tick_ms      <= 1'b0;
      tick_s       <= 1'b0;
      locked       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      rej_cnt      <= '0;
    end else begin
      if (realign) begin
        per_cnt <= '0;
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_W'(1);
      end

      if (realign || sub_wrap) begin
        sub_cnt <= '0;
      end else begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end

      if (Seconds_Load_Valid) begin
        sec_cnt <= Seconds_Load_Value;
      end else if (sec_inc) begin
        sec_cnt <= sec_cnt + SEC_W'(1);
      end

      if (realign || us_fire) begin
        us_cnt <= '0;
      end else begin
        us_cnt <= us_cnt + US_W'(1);
      end

      if (realign) begin
        ms_cnt <= '0;
      end else if (us_fire) begin
        ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + MS_W'(1);
      end

      tick_us      <= us_fire;
      tick_ms      <= us_fire && (ms_cnt == MS_LAST);
      tick_s       <= realign || sub_wrap;
      locked       <= (state_next == LOCKED);
      period_valid <= store;
      if (store) period <= elapsed;
      if (reject && (rej_cnt != REJ_MAX)) rej_cnt <= rej_cnt + REJ_W'(1);
    end
  end

  assign Seconds_Output          = sec_cnt;
  assign Subsecond_Output        = sub_cnt;
  assign Tick_1US_Output         = tick_us;
  assign Tick_1MS_Output         = tick_ms;
  assign Tick_1S_Output          = tick_s;
  assign PPS_Locked_Output       = locked;
  assign Period_Measured_Output  = period;
  assign Period_Valid_Output     = period_valid;
  assign PPS_Reject_Count_Output = rej_cnt;

endmodule

// File: tb/tb_pps_timebase_10mhz.sv
// tb/tb_pps_timebase_10mhz.sv - self-checking bench for pps_timebase_10mhz
module tb_pps_timebase_10mhz;

  localparam int CLK_HZ  = 1000;
  localparam int PPS_TOL = 10;
  localparam int US_DIV  = 10;
  localparam int MS_DIV  = 1000;
  localparam int SEC_W   = 32;
  localparam int WIN_LO  = CLK_HZ - PPS_TOL;
  localparam int WIN_HI  = CLK_HZ + PPS_TOL;

  logic             clk;
  logic             rst;
  logic             pps;
  logic             load_valid;
  logic [SEC_W-1:0] load_value;
  logic [SEC_W-1:0] seconds;
  logic [23:0]      subsec;
  logic             tick_us;
  logic             tick_ms;
  logic             tick_s;
  logic             locked;
  logic [24:0]      period;
  logic             period_valid;
  logic [7:0]       rej_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pps_timebase_10mhz #(
    .CLK_HZ  (CLK_HZ),
    .PPS_TOL (PPS_TOL),
    .SEC_W   (SEC_W),
    .US_DIV  (US_DIV)
  ) dut (
    .CLK_10MHZ_Input         (clk),
    .RST_Input               (rst),
    .PPS_Input               (pps),
    .Seconds_Load_Valid      (load_valid),
    .Seconds_Load_Value      (load_value),
    .Seconds_Output          (seconds),
    .Subsecond_Output        (subsec),
    .Tick_1US_Output         (tick_us),
    .Tick_1MS_Output         (tick_ms),
    .Tick_1S_Output          (tick_s),
    .PPS_Locked_Output       (locked),
    .Period_Measured_Output  (period),
    .Period_Valid_Output     (period_valid),
    .PPS_Reject_Count_Output (rej_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: time is an edge index; counters are derived from the
  // edge at which they were last zeroed (anchor) and the PPS rule set.
  int          t = 0;
  int          anchor;
  int          anchor_old;
  int          last_clear;
  int          el;
  int          sub_old;
  int          m_state;       // 0 free, 1 acquire, 2 locked
  bit          model_ok = 1'b0;
  bit [3:0]    hist;
  bit          rise, inwin, m_realign, m_store, m_reject, nat_wrap;
  logic [31:0] m_sec;
  int          m_sub, m_pm, m_rej;
  bit          m_tus, m_tms, m_ts, m_pv, m_lock;

  initial begin : model_and_compare
    forever begin
      @(posedge clk);
      t++;
      if (rst) begin
        anchor = t; last_clear = t; m_state = 0; hist = '0;
        m_sec = '0; m_sub = 0; m_pm = 0; m_rej = 0;
        m_tus = 0; m_tms = 0; m_ts = 0; m_pv = 0; m_lock = 0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        // PPS sampled at edge N is consumed at edge N+3.
        rise = hist[2] & ~hist[3];
        hist = {hist[2:0], pps};
        el = t - last_clear;
        inwin = (el >= WIN_LO) && (el <= WIN_HI);
        m_realign = 0; m_store = 0; m_reject = 0;
        case (m_state)
          0: if (rise) begin m_realign = 1; m_state = 1; end
          1: if (rise) begin
               m_realign = 1;
               if (inwin) begin m_store = 1; m_state = 2; end
             end else if (el > WIN_HI) m_state = 0;
          default: if (rise) begin
               if (inwin) begin m_realign = 1; m_store = 1; end
               else m_reject = 1;
             end else if (el > WIN_HI) m_state = 0;
        endcase
        anchor_old = anchor;
        sub_old  = (t - 1 - anchor_old) % CLK_HZ;
        nat_wrap = (sub_old == CLK_HZ - 1);
        m_tus = ((t - anchor_old) % US_DIV) == 0;
        m_tms = ((t - anchor_old) % (US_DIV * MS_DIV)) == 0;
        m_ts  = m_realign || nat_wrap;
        if (load_valid) m_sec = load_value;
        else if (m_realign ? (sub_old >= CLK_HZ / 2) : nat_wrap) m_sec = m_sec + 1;
        if (m_realign) begin anchor = t; last_clear = t; end
        m_sub = (t - anchor) % CLK_HZ;
        m_pv = m_store;
        if (m_store) m_pm = el;
        if (m_reject && m_rej < 255) m_rej++;
        m_lock = (m_state == 2);
      end
      #1;
      if (model_ok) begin
        chk("cyc_seconds", seconds, m_sec);
        chk("cyc_subsec", subsec, m_sub);
        chk("cyc_tick_us", tick_us, m_tus);
        chk("cyc_tick_ms", tick_ms, m_tms);
        chk("cyc_tick_s", tick_s, m_ts);
        chk("cyc_locked", locked, m_lock);
        chk("cyc_period", period, m_pm);
        chk("cyc_period_valid", period_valid, m_pv);
        chk("cyc_reject_count", rej_cnt, m_rej);
      end
    end
  end

  // Raise PPS now, report outputs three edges after it is first sampled,
  // then complete 'gap' cycles so consecutive calls are 'gap' apart (gap >= 20).
  task automatic pps_cycle(input int gap, output int o_sub, output int o_ts, output int o_pv,
                           output int o_pm, output int o_lock, output int o_sec, output int o_rej);
    pps = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    o_sub = subsec; o_ts = tick_s; o_pv = period_valid; o_pm = period;
    o_lock = locked; o_sec = seconds; o_rej = rej_cnt;
    @(negedge clk);
    repeat (16) @(negedge clk);
    pps = 1'b0;
    repeat (gap - 20) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_seconds"}, seconds, 0);
    chk({pfx, "_subsec"}, subsec, 0);
    chk({pfx, "_ticks"}, {tick_us, tick_ms, tick_s}, 0);
    chk({pfx, "_locked"}, locked, 0);
    chk({pfx, "_period"}, period, 0);
    chk({pfx, "_period_valid"}, period_valid, 0);
    chk({pfx, "_reject_count"}, rej_cnt, 0);
  endtask

  int first_us, first_s, s0, found;
  int r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej;

  initial begin : stimulus
    rst = 1'b1; pps = 1'b0; load_valid = 1'b0; load_value = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    first_us = -1; first_s = -1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (tick_us && first_us < 0) first_us = k;
      if (tick_s && first_s < 0) first_s = k;
    end
    chk("first_tick_us_cycle", first_us, 9);
    chk("first_tick_s_cycle", first_s, 999);
    chk("seconds_after_first_wrap", seconds, 1);
    @(negedge clk);

    pps_cycle(1000, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("acq_subsec", r_sub, 0);
    chk("acq_tick_s", r_ts, 1);
    chk("acq_locked", r_lock, 0);
    chk("acq_period_valid", r_pv, 0);
    chk("acq_seconds", r_sec, 1);

    pps_cycle(1000, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("lock_subsec", r_sub, 0);
    chk("lock_period_valid", r_pv, 1);
    chk("lock_period", r_pm, 1000);
    chk("lock_locked", r_lock, 1);
    chk("lock_seconds", r_sec, 2);

    pps_cycle(995, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("steady_seconds", r_sec, 3);

    pps_cycle(1005, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("early_period", r_pm, 995);
    chk("early_seconds", r_sec, 4);
    chk("early_subsec", r_sub, 0);

    pps_cycle(500, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("late_period", r_pm, 1005);
    chk("late_seconds", r_sec, 5);

    pps_cycle(500, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("reject_subsec", r_sub, 500);
    chk("reject_tick_s", r_ts, 0);
    chk("reject_period_valid", r_pv, 0);
    chk("reject_locked", r_lock, 1);
    chk("reject_count", r_rej, 1);
    chk("reject_seconds", r_sec, 5);

    pps_cycle(20, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("relock_period", r_pm, 1000);
    chk("relock_period_valid", r_pv, 1);
    chk("relock_seconds", r_sec, 6);

    // Holdover: last accepted edge consumed at N+3; timeout on the 1011th edge after it.
    repeat (994) @(posedge clk);
    #1;
    chk("holdover_locked_before_timeout", locked, 1);
    @(posedge clk); #1;
    chk("holdover_locked_after_timeout", locked, 0);
    s0 = seconds;
    repeat (1000) @(posedge clk);
    #1;
    chk("holdover_seconds_advance", seconds, s0 + 1);

    found = 0;
    for (int k = 0; k < 1100; k++) begin
      @(posedge clk); #1;
      if (subsec == 998) begin found = 1; break; end
    end
    chk("load_wait_found", found, 1);
    @(negedge clk);
    @(negedge clk);
    load_valid = 1'b1; load_value = 32'h1234;
    @(posedge clk); #1;
    chk("load_collision_seconds", seconds, 32'h1234);
    chk("load_collision_subsec", subsec, 0);
    chk("load_collision_tick_s", tick_s, 1);
    @(negedge clk);
    load_valid = 1'b0;

    pps_cycle(300, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("mid_acq_subsec", r_sub, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;

    pps_cycle(1000, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("post_reset_acq_valid", r_pv, 0);
    chk("post_reset_acq_locked", r_lock, 0);
    pps_cycle(20, r_sub, r_ts, r_pv, r_pm, r_lock, r_sec, r_rej);
    chk("post_reset_lock_period", r_pm, 1000);
    chk("post_reset_lock_locked", r_lock, 1);

    repeat (50) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
